// File: rtl/plca_pkg.sv
// Shared PLCA definitions: PCS transmit command codes, control-FSM state encodings
// and enable constants. Build option PLCA_BURST_EN selects burst support in plca_control.
package plca_pkg;

  // 5B symbols the PCS transmit path expects on tx_cmd
  localparam logic [4:0] SILENCE = 5'b11111;
  localparam logic [4:0] COMMIT  = 5'b11000;
  localparam logic [4:0] BEACON  = 5'b01000;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [3:0] {
    ST_DISABLE     = 4'd0,
    ST_RESYNC      = 4'd1,
    ST_SEND_BEACON = 4'd2,
    ST_SYNCING     = 4'd3,
    ST_WAIT_TO     = 4'd4,
    ST_COMMIT      = 4'd5,
    ST_TRANSMIT    = 4'd6,
    ST_BURST       = 4'd7,
    ST_RECEIVE     = 4'd8,
    ST_YIELD       = 4'd9,
    ST_NEXT_TX_OPP = 4'd10
  } plca_state_e;

  function automatic logic [4:0] cmd_for(input plca_state_e st);
    case (st)
      ST_SEND_BEACON:      return BEACON;
      ST_COMMIT, ST_BURST: return COMMIT;
      default:             return SILENCE;
    endcase
  endfunction

endpackage

// File: rtl/plca_timer.sv
// Loadable bit-time down-counter. start reloads LEN (a tick in that cycle is dropped);
// done rises on the cycle carrying the LEN-th tick and stays high until reloaded.
module plca_timer #(
  parameter int LEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic start,
  input  logic bit_tick,
  output logic done
);

  localparam int W = $clog2(LEN + 1);

  logic [W-1:0] cnt;
  logic         expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (start) begin
      cnt     <= W'(LEN);
      expired <= 1'b0;
    end else if (bit_tick && cnt != '0) begin
      cnt <= cnt - W'(1);
      if (cnt == W'(1)) expired <= 1'b1;
    end
  end

  assign done = expired || (bit_tick && cnt == W'(1));

endmodule

// File: rtl/plca_control.sv
// PLCA round-robin control FSM for 10BASE-T1S: beacons, transmit opportunities, commit.
// Define PLCA_BURST_EN to enable multi-frame bursts bounded by max_bc.
module plca_control
  import plca_pkg::*;
#(
  parameter int TO_BT     = 32,
  parameter int BEACON_BT = 20,
  parameter int BURST_BT  = 128
) (
  input  logic       clk,
  input  logic       plca_reset,
  input  logic       bit_tick,
  input  logic       plca_en,
  input  logic [7:0] local_nodeID,
  input  logic [7:0] node_count,
  input  logic [7:0] max_bc,
  input  logic       CRS,
  input  logic       rx_beacon,
  input  logic       packet_pending,
  input  logic       TX_EN,
  output logic [4:0] tx_cmd,
  output logic [7:0] curID,
  output logic       committed,
  output logic [3:0] plca_state
);

  plca_state_e state, state_nxt;
  logic        to_done, beacon_done, burst_done;
  logic        entering, coordinator, last_opp;
  logic [7:0]  nc_eff;

`ifdef PLCA_BURST_EN
  logic [7:0] bc;
`else
  logic unused_max_bc;
  assign unused_max_bc = ^max_bc;
`endif

  assign coordinator = (local_nodeID == 8'd0);
  assign nc_eff      = (node_count == 8'd0) ? 8'd1 : node_count;
  assign last_opp    = coordinator && ((curID + 8'd1) >= nc_eff);
  assign entering    = (state_nxt != state);
  assign plca_state  = state;

  always_ff @(posedge clk or posedge plca_reset) begin
    if (plca_reset) state <= ST_DISABLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DISABLE:     if (plca_en == ENABLE) state_nxt = ST_RESYNC;
      ST_RESYNC:      if (coordinator && to_done && !CRS) state_nxt = ST_SEND_BEACON;
      ST_SEND_BEACON: if (beacon_done) state_nxt = ST_SYNCING;
      ST_SYNCING:     if (!CRS) state_nxt = ST_WAIT_TO;
      ST_WAIT_TO: begin
        if (CRS)                                                  state_nxt = ST_RECEIVE;
        else if ((curID == local_nodeID) && packet_pending)       state_nxt = ST_COMMIT;
        else if (to_done)                                         state_nxt = ST_NEXT_TX_OPP;
      end
      ST_COMMIT: begin
        if (TX_EN)        state_nxt = ST_TRANSMIT;
        else if (to_done) state_nxt = ST_YIELD;
      end
      ST_TRANSMIT: begin
        if (!TX_EN) begin
`ifdef PLCA_BURST_EN
          state_nxt = (bc < max_bc) ? ST_BURST : ST_YIELD;
`else
          state_nxt = ST_YIELD;
`endif
        end
      end
      ST_BURST: begin
        if (TX_EN)           state_nxt = ST_TRANSMIT;
        else if (burst_done) state_nxt = ST_YIELD;
      end
      ST_RECEIVE:     if (!CRS) state_nxt = ST_NEXT_TX_OPP;
      ST_YIELD:       state_nxt = ST_NEXT_TX_OPP;
      ST_NEXT_TX_OPP: state_nxt = last_opp ? ST_SEND_BEACON : ST_WAIT_TO;
      default:        state_nxt = ST_DISABLE;
    endcase
    // A beacon on the line resynchronises everyone not currently driving the medium
    if (rx_beacon && !(state inside {ST_DISABLE, ST_SEND_BEACON, ST_COMMIT,
                                     ST_TRANSMIT, ST_BURST}))
      state_nxt = ST_SYNCING;
    if (plca_en == DISABLE) state_nxt = ST_DISABLE;
  end

  // Moore outputs registered from the next state so they change on the entry edge
  always_ff @(posedge clk or posedge plca_reset) begin
    if (plca_reset) begin
      tx_cmd    <= SILENCE;
      committed <= 1'b0;
      curID     <= 8'd0;
    end else begin
      tx_cmd    <= cmd_for(state_nxt);
      committed <= (state_nxt inside {ST_COMMIT, ST_TRANSMIT, ST_BURST});
      if (state_nxt == ST_DISABLE || state_nxt == ST_SYNCING)
        curID <= 8'd0;
      else if (state == ST_NEXT_TX_OPP && state_nxt == ST_WAIT_TO)
        curID <= curID + 8'd1;
    end
  end

`ifdef PLCA_BURST_EN
  always_ff @(posedge clk or posedge plca_reset) begin
    if (plca_reset) begin
      bc <= 8'd0;
    end else if (state_nxt inside {ST_DISABLE, ST_SYNCING, ST_NEXT_TX_OPP}) begin
      bc <= 8'd0;
    end else if (state == ST_TRANSMIT && state_nxt == ST_BURST) begin
      bc <= bc + 8'd1;
    end
  end
`endif

  plca_timer #(.LEN(TO_BT)) u_to_timer (
    .clk(clk), .rst(plca_reset), .clr(plca_en == DISABLE),
    .start(entering && (state_nxt == ST_RESYNC || state_nxt == ST_WAIT_TO)),
    .bit_tick(bit_tick), .done(to_done)
  );

  plca_timer #(.LEN(BEACON_BT)) u_beacon_timer (
    .clk(clk), .rst(plca_reset), .clr(plca_en == DISABLE),
    .start(entering && state_nxt == ST_SEND_BEACON),
    .bit_tick(bit_tick), .done(beacon_done)
  );

  plca_timer #(.LEN(BURST_BT)) u_burst_timer (
    .clk(clk), .rst(plca_reset), .clr(plca_en == DISABLE),
    .start(entering && state_nxt == ST_BURST),
    .bit_tick(bit_tick), .done(burst_done)
  );

endmodule

// File: tb/tb_plca_control.sv
// Directed bench for plca_control; bit_tick mostly held high so one bit time = one clock.
// Expectations for burst behaviour follow PLCA_BURST_EN as compiled.
module tb_plca_control;
  import plca_pkg::*;

  localparam logic [3:0] S_DIS = 4'd0, S_RESYNC = 4'd1, S_BEACON = 4'd2, S_SYNC = 4'd3,
                         S_WAIT = 4'd4, S_COMMIT = 4'd5, S_TX = 4'd6, S_BURST = 4'd7,
                         S_RX = 4'd8, S_YIELD = 4'd9, S_NEXT = 4'd10;

  logic       clk = 1'b0;
  logic       plca_reset = 1'b1;
  logic       bit_tick = 1'b1;
  logic       plca_en = 1'b0;
  logic [7:0] local_nodeID = 8'd0;
  logic [7:0] node_count = 8'd3;
  logic [7:0] max_bc = 8'd0;
  logic       CRS = 1'b0;
  logic       rx_beacon = 1'b0;
  logic       packet_pending = 1'b0;
  logic       TX_EN = 1'b0;
  logic [4:0] tx_cmd;
  logic [7:0] curID;
  logic       committed;
  logic [3:0] plca_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  plca_control dut (
    .clk(clk), .plca_reset(plca_reset), .bit_tick(bit_tick), .plca_en(plca_en),
    .local_nodeID(local_nodeID), .node_count(node_count), .max_bc(max_bc),
    .CRS(CRS), .rx_beacon(rx_beacon), .packet_pending(packet_pending), .TX_EN(TX_EN),
    .tx_cmd(tx_cmd), .curID(curID), .committed(committed), .plca_state(plca_state)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [4:0] cmd,
                         input logic [7:0] id, input logic comm);
    chk({tag, ".state"}, {4'd0, plca_state}, {4'd0, st});
    chk({tag, ".tx_cmd"}, {3'd0, tx_cmd}, {3'd0, cmd});
    chk({tag, ".curID"}, curID, id);
    chk({tag, ".committed"}, {7'd0, committed}, {7'd0, comm});
  endtask

  initial begin
    // Reset state
    step(2);
    chk_all("reset", S_DIS, SILENCE, 8'd0, 1'b0);
    plca_reset = 1'b0;
    step(1);
    chk_all("idle_disabled", S_DIS, SILENCE, 8'd0, 1'b0);

    // Coordinator, node_count=3, idle bus
    plca_en = 1'b1;
    step(1);
    chk_all("c_resync", S_RESYNC, SILENCE, 8'd0, 1'b0);
    step(31);
    chk_all("c_resync_end", S_RESYNC, SILENCE, 8'd0, 1'b0);
    step(1);
    chk_all("c_beacon", S_BEACON, BEACON, 8'd0, 1'b0);
    step(19);
    chk_all("c_beacon_end", S_BEACON, BEACON, 8'd0, 1'b0);
    step(1);
    chk_all("c_sync", S_SYNC, SILENCE, 8'd0, 1'b0);
    step(1);
    chk_all("c_wait0", S_WAIT, SILENCE, 8'd0, 1'b0);
    step(31);
    chk_all("c_wait0_end", S_WAIT, SILENCE, 8'd0, 1'b0);
    step(1);
    chk_all("c_next0", S_NEXT, SILENCE, 8'd0, 1'b0);
    step(1);
    chk_all("c_wait1", S_WAIT, SILENCE, 8'd1, 1'b0);
    step(32);
    chk_all("c_next1", S_NEXT, SILENCE, 8'd1, 1'b0);
    step(1);
    chk_all("c_wait2", S_WAIT, SILENCE, 8'd2, 1'b0);
    step(32);
    chk_all("c_next2", S_NEXT, SILENCE, 8'd2, 1'b0);
    step(1);
    chk_all("c_beacon2", S_BEACON, BEACON, 8'd2, 1'b0);

    // Timers freeze without bit_tick
    bit_tick = 1'b0;
    step(50);
    chk_all("c_beacon_notick", S_BEACON, BEACON, 8'd2, 1'b0);
    bit_tick = 1'b1;

    // plca_en low forces DISABLE and reset outputs
    plca_en = 1'b0;
    step(1);
    chk_all("c_disabled", S_DIS, SILENCE, 8'd0, 1'b0);

    // Follower ID 2 with a frame pending
    local_nodeID = 8'd2;
    packet_pending = 1'b1;
    plca_en = 1'b1;
    step(1);
    chk_all("f_resync", S_RESYNC, SILENCE, 8'd0, 1'b0);
    step(40);
    chk_all("f_resync_hold", S_RESYNC, SILENCE, 8'd0, 1'b0);
    rx_beacon = 1'b1;
    step(1);
    rx_beacon = 1'b0;
    chk_all("f_sync", S_SYNC, SILENCE, 8'd0, 1'b0);
    step(1);
    chk_all("f_wait0", S_WAIT, SILENCE, 8'd0, 1'b0);
    step(33);
    chk_all("f_wait1", S_WAIT, SILENCE, 8'd1, 1'b0);
    step(33);
    chk_all("f_wait2", S_WAIT, SILENCE, 8'd2, 1'b0);
    step(1);
    chk_all("f_commit", S_COMMIT, COMMIT, 8'd2, 1'b1);
    TX_EN = 1'b1;
    step(1);
    chk_all("f_tx", S_TX, SILENCE, 8'd2, 1'b1);
    step(5);
    TX_EN = 1'b0;
    step(1);
    chk_all("f_yield", S_YIELD, SILENCE, 8'd2, 1'b0);
    step(1);
    chk_all("f_next", S_NEXT, SILENCE, 8'd2, 1'b0);
    step(1);
    chk_all("f_wait3", S_WAIT, SILENCE, 8'd3, 1'b0);

    // Burst: max_bc=2, three frames in one opportunity when enabled
    local_nodeID = 8'd3;
    max_bc = 8'd2;
    step(1);
    chk_all("b_commit", S_COMMIT, COMMIT, 8'd3, 1'b1);
    TX_EN = 1'b1;
    step(1);
    chk_all("b_tx1", S_TX, SILENCE, 8'd3, 1'b1);
    step(3);
    TX_EN = 1'b0;
    step(1);
`ifdef PLCA_BURST_EN
    chk_all("b_burst1", S_BURST, COMMIT, 8'd3, 1'b1);
    TX_EN = 1'b1;
    step(1);
    chk_all("b_tx2", S_TX, SILENCE, 8'd3, 1'b1);
    TX_EN = 1'b0;
    step(1);
    chk_all("b_burst2", S_BURST, COMMIT, 8'd3, 1'b1);
    TX_EN = 1'b1;
    step(1);
    chk_all("b_tx3", S_TX, SILENCE, 8'd3, 1'b1);
    TX_EN = 1'b0;
    step(1);
`endif
    chk_all("b_yield", S_YIELD, SILENCE, 8'd3, 1'b0);
    step(2);
    chk_all("b_wait4", S_WAIT, SILENCE, 8'd4, 1'b0);

    // CRS together with own-slot commit: RECEIVE wins
    local_nodeID = 8'd4;
    CRS = 1'b1;
    step(1);
    chk_all("r_receive", S_RX, SILENCE, 8'd4, 1'b0);
    step(3);
    chk_all("r_hold", S_RX, SILENCE, 8'd4, 1'b0);
    CRS = 1'b0;
    step(1);
    chk_all("r_next", S_NEXT, SILENCE, 8'd4, 1'b0);
    step(1);
    chk_all("r_wait5", S_WAIT, SILENCE, 8'd5, 1'b0);

    // rx_beacon beats the own-slot commit in WAIT_TO
    local_nodeID = 8'd5;
    rx_beacon = 1'b1;
    step(1);
    rx_beacon = 1'b0;
    chk_all("s_resync_beacon", S_SYNC, SILENCE, 8'd0, 1'b0);
    step(1);
    chk_all("s_wait0", S_WAIT, SILENCE, 8'd0, 1'b0);

    // Asynchronous reset mid-frame
    local_nodeID = 8'd1;
    step(33);
    chk_all("a_wait1", S_WAIT, SILENCE, 8'd1, 1'b0);
    step(1);
    chk_all("a_commit", S_COMMIT, COMMIT, 8'd1, 1'b1);
    TX_EN = 1'b1;
    step(1);
    chk_all("a_tx", S_TX, SILENCE, 8'd1, 1'b1);
    #2;
    plca_reset = 1'b1;
    #1;
    chk_all("a_async_reset", S_DIS, SILENCE, 8'd0, 1'b0);
    #1;
    plca_reset = 1'b0;
    TX_EN = 1'b0;
    packet_pending = 1'b0;
    #1;
    chk_all("a_released", S_DIS, SILENCE, 8'd0, 1'b0);
    step(1);
    chk_all("a_restart", S_RESYNC, SILENCE, 8'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plca_control.md
# plca_control

Physical Layer Collision Avoidance (PLCA) control state machine for the 10BASE-T1S multidrop PHY. It arbitrates the shared medium by round-robin transmit opportunities numbered by `curID`. It issues BEACON, COMMIT and SILENCE commands on `tx_cmd` to the PCS transmit state diagram. It sits between the MAC/RS (`packet_pending`, `TX_EN`) and the PCS transmit (`tx_cmd`), and takes carrier and beacon indications from the PCS receive path.

## Interface
- `TO_BT`, 32: transmit-opportunity timer length, in bit times.
- `BEACON_BT`, 20: beacon transmit duration, in bit times.
- `BURST_BT`, 128: burst inter-frame window, in bit times.
- `clk` in 1: single clock; all state changes on the rising edge.
- `plca_reset` in 1: asynchronous, active-high reset.
- `bit_tick` in 1: one-cycle strobe per bit time; all timers advance only on it.
- `plca_en` in 1: PLCA enable; low forces DISABLE.
- `local_nodeID` in 8: this node's ID; 0 means coordinator.
- `node_count` in 8: number of opportunities per cycle; used by the coordinator only; 0 is treated as 1.
- `max_bc` in 8: maximum extra frames per opportunity.
- `CRS` in 1: receive carrier sense.
- `rx_beacon` in 1: one-cycle pulse when a BEACON is decoded on the line.
- `packet_pending` in 1: MAC has a frame queued.
- `TX_EN` in 1: MII transmit enable.
- `tx_cmd` out 5: SILENCE, COMMIT or BEACON code to the PCS.
- `curID` out 8: current opportunity ID.
- `committed` out 1: node owns the medium (COMMIT, TRANSMIT, BURST).
- `plca_state` out 4: state encoding, for debug.

## Operation
- Reset values: state DISABLE, `tx_cmd`=SILENCE, `curID`=0, `committed`=0, burst count `bc`=0, all timers cleared.
- The same values apply whenever `plca_en`=0, from any state.
- State encodings: DISABLE 0, RESYNC 1, SEND_BEACON 2, SYNCING 3, WAIT_TO 4, COMMIT 5, TRANSMIT 6, BURST 7, RECEIVE 8, YIELD 9, NEXT_TX_OPP 10.
- **DISABLE**: on `plca_en` go to RESYNC.
- **RESYNC**: `rx_beacon` goes to SYNCING. A coordinator also starts `to_timer`; on expiry with `CRS`=0 it goes to SEND_BEACON.
- **SEND_BEACON**: `tx_cmd`=BEACON and `beacon_timer` starts. On expiry go to SYNCING.
- **SYNCING**: `curID`=0, `bc`=0, `tx_cmd`=SILENCE. When `CRS`=0 go to WAIT_TO.
- **WAIT_TO**: `to_timer` restarts on entry. Exits, in priority order:
  - `CRS` goes to RECEIVE.
  - `curID`==`local_nodeID` and `packet_pending` goes to COMMIT.
  - `to_timer` expiry goes to NEXT_TX_OPP.
- **COMMIT**: `tx_cmd`=COMMIT, `committed`=1. `TX_EN` goes to TRANSMIT. `to_timer` expiry without `TX_EN` goes to YIELD.
- **TRANSMIT**: `tx_cmd`=SILENCE. On `TX_EN` falling:
  - if `bc`<`max_bc`, increment `bc` and go to BURST;
  - otherwise go to YIELD.
- **BURST**: `tx_cmd`=COMMIT and `burst_timer` starts. `TX_EN` goes to TRANSMIT. Expiry goes to YIELD.
- **RECEIVE**: `CRS` falling goes to NEXT_TX_OPP.
- **YIELD**: `committed`=0, `tx_cmd`=SILENCE. Go to NEXT_TX_OPP on the next cycle.
- **NEXT_TX_OPP**: `bc`=0.
  - Coordinator with `curID`+1 ≥ max(`node_count`,1): go to SEND_BEACON.
  - Otherwise: `curID` increments (mod 256) and the state goes to WAIT_TO.
- `rx_beacon` in any state except DISABLE, SEND_BEACON, COMMIT, TRANSMIT or BURST goes to SYNCING. It takes priority over all other exits.
- Arithmetic is 8-bit unsigned. The `curID` compare uses the pre-increment value.

## Timing
- Registered Moore outputs: `tx_cmd`, `committed` and `curID` take their new values on the same edge the state is entered.
- Timer done is asserted on the cycle carrying the Nth `bit_tick` after entry. The transition happens on the following edge.
- The counter restarts on the entry edge; a `bit_tick` on the entry cycle is not counted.
- Minimum dwell is one cycle in every state. YIELD and NEXT_TX_OPP each last exactly one cycle.
- From `packet_pending` seen in WAIT_TO with `curID`==`local_nodeID` to `tx_cmd`=COMMIT: 1 cycle.
- `TX_EN` rising and `to_timer` expiry in the same COMMIT cycle: go to TRANSMIT.
- `CRS` rising and the own-slot commit condition in the same cycle: go to RECEIVE.
- `plca_reset` mid-frame: all outputs return to reset values immediately (asynchronous), including `tx_cmd`=SILENCE.

## Configuration
- `PLCA_BURST_EN` defined: BURST state and `bc` are implemented as described.
- `PLCA_BURST_EN` undefined:
  - `max_bc` is ignored and BURST is unreachable;
  - TRANSMIT always exits to YIELD;
  - `bc` is removed.

## Structure
- Package `plca_pkg` holds:
  - the `tx_cmd` codes SILENCE, COMMIT and BEACON, identical to the codes consumed by the PCS transmit;
  - the state encodings;
  - ENABLE/DISABLE constants.
- One sub-module, `plca_timer`: a loadable `bit_tick` down-counter with start and done signals. It is instantiated three times, for `to_timer`, `beacon_timer` and `burst_timer`.

## Test plan
- Coordinator, `node_count`=3, idle bus: BEACON for 20 bit times, then `curID` 0→1→2 each after 32 bit times, then BEACON again.
- Follower, `local_nodeID`=2, `packet_pending`=1:
  - `rx_beacon` leads to SYNCING, then `curID`=2 after 64 bit times;
  - COMMIT is issued 1 cycle later;
  - `TX_EN` gives TRANSMIT, and frame end gives YIELD and `curID`=3.
- `max_bc`=2 with `PLCA_BURST_EN` defined: three back-to-back frames in one opportunity with COMMIT between them. The third frame end goes to YIELD.
- Same stimulus without the macro: YIELD after the first frame.
- `CRS` asserted on the same edge as the own-slot commit goes to RECEIVE with `committed`=0. `CRS` falling gives NEXT_TX_OPP.
- `plca_reset` pulsed during TRANSMIT: `tx_cmd`=SILENCE, `curID`=0, `committed`=0 without waiting for `clk`. After release the block restarts in DISABLE.
